// File: rtl/mano_pkg.sv
// Shared definitions for the memory-reference instruction sequencer:
// opcodes, AC function encodings and the sequencer state type.
package mano_pkg;

  localparam logic [2:0] OPC_AND = 3'd0;
  localparam logic [2:0] OPC_ADD = 3'd1;
  localparam logic [2:0] OPC_LDA = 3'd2;
  localparam logic [2:0] OPC_ISZ = 3'd6;

  localparam logic [1:0] ACOP_AND  = 2'd0;
  localparam logic [1:0] ACOP_ADD  = 2'd1;
  localparam logic [1:0] ACOP_LOAD = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_EXE, S_INC, S_WR, S_SKIP, S_FIN
  } mri_state_t;

  function automatic logic opc_legal(input logic [2:0] opc);
    return (opc == OPC_AND) || (opc == OPC_ADD) || (opc == OPC_LDA) || (opc == OPC_ISZ);
  endfunction

  // Only meaningful for AND/ADD/LDA; ISZ never reaches EXE.
  function automatic logic [1:0] ac_op_of(input logic [2:0] opc);
    case (opc)
      OPC_ADD: return ACOP_ADD;
      OPC_LDA: return ACOP_LOAD;
      default: return ACOP_AND;
    endcase
  endfunction

endpackage

// File: rtl/mem_ack_watchdog.sv
// MEM_ACK wait counter; only built when MRI_TIMEOUT_EN is defined.
// Counts request cycles without ACK and flags expiry on the TIMEOUT-th one.
`ifdef MRI_TIMEOUT_EN
module mem_ack_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic CLK,
  input  logic CLR_N,
  input  logic active,
  input  logic ack,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Clearing whenever no request is outstanding gives a fresh count on every RD/WR entry.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N)              cnt <= '0;
    else if (!active || ack) cnt <= '0;
    else                     cnt <= cnt + CW'(1);
  end

  assign expire = active && !ack && (cnt == CW'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/mri_dr_ctrl.sv
// DR sequencer for memory-reference instructions (AND/ADD/LDA/ISZ).
// Optional MEM_ACK timeout enabled by defining MRI_TIMEOUT_EN.
module mri_dr_ctrl
  import mano_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        CLR_N,
  input  logic        START,
  input  logic [2:0]  OPC,
  input  logic [15:0] DR,
  input  logic        MEM_ACK,
  output logic        DR_LD,
  output logic        DR_INR,
  output logic        MEM_RD,
  output logic        MEM_WR,
  output logic        BUS_DR,
  output logic [1:0]  AC_OP,
  output logic        AC_LD,
  output logic        PC_INR,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  mri_state_t state, nxt;
  logic [2:0] opc_q, opc_d;
  logic       err_q, err_d;
  logic       tmo;

`ifdef MRI_TIMEOUT_EN
  mem_ack_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .CLK    (CLK),
    .CLR_N  (CLR_N),
    .active ((state == S_RD) || (state == S_WR)),
    .ack    (MEM_ACK),
    .expire (tmo)
  );
`else
  // No watchdog: RD/WR wait for ACK indefinitely (TIMEOUT is never negative).
  assign tmo = (TIMEOUT < 0);
`endif

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state <= S_IDLE;
      opc_q <= OPC_AND;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      opc_q <= opc_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    nxt   = state;
    opc_d = opc_q;
    err_d = 1'b0;
    case (state)
      S_IDLE: if (START) begin
        if (opc_legal(OPC)) begin
          nxt   = S_RD;
          opc_d = OPC;
        end else begin
          err_d = 1'b1;
        end
      end
      S_RD: begin
        if (MEM_ACK) nxt = (opc_q == OPC_ISZ) ? S_INC : S_EXE;
        else if (tmo) begin
          nxt   = S_IDLE;
          err_d = 1'b1;
        end
      end
      S_EXE: nxt = S_FIN;
      S_INC: nxt = S_WR;
      // DR already holds the incremented word while the write is in flight.
      S_WR: begin
        if (MEM_ACK) nxt = (DR == 16'h0000) ? S_SKIP : S_FIN;
        else if (tmo) begin
          nxt   = S_IDLE;
          err_d = 1'b1;
        end
      end
      S_SKIP: nxt = S_FIN;
      S_FIN:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  assign MEM_RD = (state == S_RD);
  assign DR_LD  = (state == S_RD) && MEM_ACK;
  assign DR_INR = (state == S_INC);
  assign MEM_WR = (state == S_WR);
  assign BUS_DR = (state == S_WR);
  assign AC_LD  = (state == S_EXE);
  assign AC_OP  = (state == S_EXE) ? ac_op_of(opc_q) : ACOP_AND;
  assign PC_INR = (state == S_SKIP);
  assign BUSY   = (state != S_IDLE);
  assign DONE   = (state == S_FIN);
  assign ERR    = err_q;

endmodule

// File: tb/tb_mri_dr_ctrl.sv
// Directed, table-driven bench for mri_dr_ctrl with a behavioural DR/memory.
// Builds with or without MRI_TIMEOUT_EN.
module tb_mri_dr_ctrl;

  logic        CLK = 1'b0;
  logic        CLR_N = 1'b0;
  logic        START = 1'b0;
  logic [2:0]  OPC = 3'd0;
  logic [15:0] DR;
  logic        MEM_ACK = 1'b0;
  logic        DR_LD, DR_INR, MEM_RD, MEM_WR, BUS_DR, AC_LD, PC_INR, BUSY, DONE, ERR;
  logic [1:0]  AC_OP;

  logic [15:0] dr_m = 16'h0;
  logic [15:0] mem_word = 16'h0;
  int checks = 0;
  int failures = 0;

  assign DR = dr_m;

  mri_dr_ctrl #(.TIMEOUT(15)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .START(START), .OPC(OPC), .DR(DR), .MEM_ACK(MEM_ACK),
    .DR_LD(DR_LD), .DR_INR(DR_INR), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .BUS_DR(BUS_DR),
    .AC_OP(AC_OP), .AC_LD(AC_LD), .PC_INR(PC_INR), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // The DR register itself: loads from the memory bus or increments.
  always @(posedge CLK) begin
    if (DR_LD)       dr_m <= mem_word;
    else if (DR_INR) dr_m <= dr_m + 16'h1;
  end

  localparam logic [11:0] LD  = 12'h800, INR = 12'h400, RD  = 12'h200, WR = 12'h100,
                          BUS = 12'h080, OP1 = 12'h020, OP2 = 12'h040, ACL = 12'h010,
                          PCI = 12'h008, BSY = 12'h004, DN  = 12'h002, ER = 12'h001;

  typedef struct {
    logic        start;
    logic [2:0]  opc;
    logic        ack;
    logic [15:0] mem;
    logic [11:0] exp;
  } vec_t;

  vec_t vt[$];

  function automatic logic [11:0] outs();
    return {DR_LD, DR_INR, MEM_RD, MEM_WR, BUS_DR, AC_OP, AC_LD, PC_INR, BUSY, DONE, ERR};
  endfunction

  task automatic add(input logic s, input logic [2:0] o, input logic a,
                     input logic [15:0] m, input logic [11:0] e);
    vec_t v;
    v.start = s; v.opc = o; v.ack = a; v.mem = m; v.exp = e;
    vt.push_back(v);
  endtask

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %03h expected %03h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One cycle: drive just after the rising edge, sample at the falling edge.
  task automatic cyc(input logic s, input logic [2:0] o, input logic a, input logic [15:0] m);
    @(posedge CLK);
    #1;
    START = s; OPC = o; MEM_ACK = a; mem_word = m;
    @(negedge CLK);
  endtask

  initial begin
    // Vector i's outputs reflect the state entered at its own rising edge.
    // ADD, ACK on first RD cycle; START in FIN ignored, START right after DONE accepted.
    add(1, 3'd1, 0, 16'h0000, 12'h000);
    add(0, 3'd0, 1, 16'h1234, LD|RD|BSY);
    add(0, 3'd0, 1, 16'h0000, ACL|OP1|BSY);
    add(1, 3'd0, 0, 16'h0000, DN|BSY);
    // LDA with ACK delayed 4 cycles
    add(1, 3'd2, 0, 16'h0000, 12'h000);
    add(0, 3'd0, 0, 16'h0000, RD|BSY);
    add(0, 3'd0, 0, 16'h0000, RD|BSY);
    add(0, 3'd0, 0, 16'h0000, RD|BSY);
    add(0, 3'd0, 0, 16'h0000, RD|BSY);
    add(0, 3'd0, 1, 16'h00AA, LD|RD|BSY);
    add(0, 3'd0, 0, 16'h0000, ACL|OP2|BSY);
    add(0, 3'd0, 0, 16'h0000, DN|BSY);
    // Illegal opcode 3
    add(1, 3'd3, 0, 16'h0000, 12'h000);
    add(0, 3'd0, 0, 16'h0000, ER);
    // ISZ on FFFF: wraps to 0000 and skips
    add(1, 3'd6, 0, 16'h0000, 12'h000);
    add(0, 3'd0, 1, 16'hFFFF, LD|RD|BSY);
    add(0, 3'd0, 1, 16'h0000, INR|BSY);
    add(0, 3'd0, 1, 16'h0000, WR|BUS|BSY);
    add(0, 3'd0, 0, 16'h0000, PCI|BSY);
    add(0, 3'd0, 0, 16'h0000, DN|BSY);
    // ISZ on 0041 with one-cycle write delay: no skip
    add(1, 3'd6, 0, 16'h0000, 12'h000);
    add(0, 3'd0, 1, 16'h0041, LD|RD|BSY);
    add(0, 3'd0, 0, 16'h0000, INR|BSY);
    add(0, 3'd0, 0, 16'h0000, WR|BUS|BSY);
    add(0, 3'd0, 1, 16'h0000, WR|BUS|BSY);
    add(0, 3'd0, 0, 16'h0000, DN|BSY);
    // AND with stray ACK while idle
    add(1, 3'd0, 1, 16'h0000, 12'h000);
    add(0, 3'd0, 1, 16'h0F0F, LD|RD|BSY);
    add(0, 3'd0, 0, 16'h0000, ACL|BSY);
    add(0, 3'd0, 0, 16'h0000, DN|BSY);
    // Illegal opcode 7
    add(1, 3'd7, 0, 16'h0000, 12'h000);
    add(0, 3'd0, 0, 16'h0000, ER);
    add(0, 3'd0, 0, 16'h0000, 12'h000);

    #1;
    check("reset_outputs", outs(), 12'h000);
    repeat (2) @(posedge CLK);
    #2 CLR_N = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      cyc(vt[i].start, vt[i].opc, vt[i].ack, vt[i].mem);
      check($sformatf("vec%0d", i), outs(), vt[i].exp);
      if (i == 18) check("isz_wrap_dr", {12'h000}, {dr_m[11:0] | {8'h0, dr_m[15:12]}});
      if (i == 25) check("isz_inc_dr", {dr_m[11:0]}, 12'h042);
    end

    // Reset in the middle of an ISZ write
    cyc(1, 3'd6, 0, 16'h0000);
    cyc(0, 3'd0, 1, 16'h7000);
    cyc(0, 3'd0, 0, 16'h0000);
    cyc(0, 3'd0, 0, 16'h0000);
    check("isz_in_wr", outs(), WR|BUS|BSY);
    #1 CLR_N = 1'b0;
    #1 check("async_reset", outs(), 12'h000);
    @(posedge CLK);
    #2 CLR_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 3'd0, (i == 0), 16'h0000);
      check($sformatf("post_reset%0d", i), outs(), 12'h000);
    end

`ifdef MRI_TIMEOUT_EN
    begin
      int rd_cnt = 0;
      int bad = 0;
      int seen = 0;
      cyc(1, 3'd2, 0, 16'h0000);
      for (int i = 0; i < 40; i++) begin
        cyc(0, 3'd0, 0, 16'h0000);
        if (MEM_RD) rd_cnt++;
        if (DR_LD || DONE || AC_LD) bad++;
        if (ERR) begin
          seen = 1;
          break;
        end
      end
      check_int("tmo_err_seen", seen, 1);
      check_int("tmo_rd_cycles", rd_cnt, 15);
      check_int("tmo_no_strobes", bad, 0);
      cyc(0, 3'd0, 0, 16'h0000);
      check("tmo_idle", outs(), 12'h000);
    end
`else
    begin
      int rd_cnt = 0;
      cyc(1, 3'd2, 0, 16'h0000);
      for (int i = 0; i < 30; i++) begin
        cyc(0, 3'd0, 0, 16'h0000);
        if (MEM_RD && !ERR) rd_cnt++;
      end
      check_int("long_wait_rd", rd_cnt, 30);
      cyc(0, 3'd0, 1, 16'h5555);
      check("long_wait_ack", outs(), LD|RD|BSY);
      cyc(0, 3'd0, 0, 16'h0000);
      check("long_wait_exe", outs(), ACL|OP2|BSY);
      cyc(0, 3'd0, 0, 16'h0000);
      check("long_wait_done", outs(), DN|BSY);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
